parity_frame_tx: RTL and testbench



---
 rtl/parity_frame_tx.sv | 121 ++++++++++++
 tb/tb_parity_frame_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_tx.sv
`default_nettype none
// parity_frame_tx: accepts a byte and sends it as an odd-parity frame, LSB first, on an idle-high line.
// Frame layout is start, data[0..7], parity, stop. Rev 1.0
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int                 c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_q, par_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == c_cnt_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d always carries the level of the bit that starts on the next cycle,
  // so the line is registered yet changes exactly at each bit boundary.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + c_cnt_one;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (valid_in) begin
          shift_d = data_in;
          par_d   = ~^data_in;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx_out    = tx_q;
  assign ready_out = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_STOP) && bit_end;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// tb_parity_frame_tx: handshake-driven scoreboard; a line monitor decodes each frame and checks it
// against a frame model built from the data byte and its ones-count.
module tb_parity_frame_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, tx_out, busy, done;

  parity_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx_out    (tx_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   acc_log[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nframes = 0;
  bit   in_frame = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit 0 is the start bit, bit 10 the stop bit; parity makes the data+P weight odd.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  initial begin : acceptor
    forever begin
      @(posedge clk);
      if (!rst && valid_in && ready_out) begin
        q.push_back('{d: data_in, acc: cyc});
        acc_log.push_back(cyc);
      end
      cyc = cyc + 1;
    end
  end

  initial begin : monitor
    exp_t        cur;
    int          pos;
    logic [10:0] rx;
    bit          done_bad, hs_bad, post_rst;
    pos = 0; rx = '0; done_bad = 0; hs_bad = 0; post_rst = 0;
    cur = '{d: 8'h00, acc: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_frame && q.size() > 0) void'(q.pop_front());
        in_frame = 1'b0;
        post_rst = 1'b1;
        continue;
      end
      if (post_rst) begin
        post_rst = 1'b0;
        chk("post_reset_outputs", {28'd0, tx_out, ready_out, busy, done}, 32'b1100);
        continue;
      end
      if (!in_frame) begin
        if (tx_out === 1'b0) begin
          if (q.size() == 0) begin
            chk("unexpected_frame_start", 32'd1, 32'd0);
          end else begin
            cur = q[0];
            chk("start_latency", cyc, cur.acc + 1);
            in_frame = 1'b1; pos = 0; rx = '0; done_bad = 0; hs_bad = 0;
          end
        end else begin
          chk("idle_outputs", {29'd0, ready_out, busy, done}, 32'b100);
        end
      end
      if (in_frame) begin
        if (done !== (pos == FRAME - 1)) done_bad = 1'b1;
        if (ready_out !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
        if (pos % CPB == CPB / 2) rx[pos / CPB] = tx_out;
        if (pos == FRAME - 1) begin
          void'(q.pop_front());
          chk("frame_bits", {21'd0, rx}, {21'd0, model_frame(cur.d)});
          chk("odd_weight", $countones(rx[9:1]) % 2, 32'd1);
          chk("done_pulse", {31'd0, done_bad}, 32'd0);
          chk("busy_ready_in_frame", {31'd0, hs_bad}, 32'd0);
          in_frame = 1'b0;
          nframes++;
        end
        pos++;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int n0);
    int k;
    k = 0;
    while (acc_log.size() == n0 && k < 300) begin
      tick(1);
      k++;
    end
    if (acc_log.size() == n0) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n0;
    n0 = acc_log.size();
    data_in  = d;
    valid_in = 1'b1;
    wait_acc(n0);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || in_frame || !ready_out) && k < 2000) begin
      tick(1);
      k++;
    end
    if (q.size() != 0 || in_frame) chk("drain_timeout", 32'd1, 32'd0);
    tick(2);
  endtask

  initial begin : stimulus
    int n0;
    logic [7:0] bytes [5];
    bytes = '{8'h00, 8'hFF, 8'h01, 8'hA5, 8'h07};

    tick(3);
    rst = 1'b0;
    tick(20);

    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      drain();
    end

    // Back-to-back with valid held high the whole time.
    n0 = acc_log.size();
    data_in  = 8'h3C;
    valid_in = 1'b1;
    wait_acc(n0);
    data_in = 8'hC3;
    wait_acc(n0 + 1);
    valid_in = 1'b0;
    if (acc_log.size() >= 2)
      chk("b2b_interval", acc_log[$] - acc_log[$-1], FRAME + 1);
    drain();

    send_byte(8'h55);
    data_in = 8'hAA;
    drain();

    // Reset and valid together: nothing may be accepted.
    data_in  = 8'h99;
    valid_in = 1'b1;
    rst      = 1'b1;
    tick(3);
    rst      = 1'b0;
    valid_in = 1'b0;
    tick(5);

    // Reset during data bit index 3, then a fresh frame.
    send_byte(8'h3E);
    tick(16);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    send_byte(8'h80);
    drain();

    for (int i = 0; i < 1500; i++) begin
      valid_in = ($urandom_range(0, 3) == 0);
      data_in  = 8'($urandom);
      tick(1);
    end
    valid_in = 1'b0;
    drain();

    chk("frame_count", nframes, acc_log.size() - 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
